// File: rtl/uart_rx_core.sv
// 8N1 UART receiver. It synchronises the serial line, samples each bit at mid-bit and
// presents each good byte on a valid/ready output register.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_s;
  logic          deliver;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    timer_d     = timer_q;
    index_d     = index_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    deliver     = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          index_d = 3'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d          = '0;
          shift_d[index_q] = rx_s;
          if (index_q == 3'd7) state_d = S_STOP;
          else                 index_d = index_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BREAK: begin
        // A line held low must return high before a new frame can begin.
        timer_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (clr_err)                overrun_d  = 1'b0;
    // A handshake in the same cycle frees the register, so the new byte is not lost.
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      index_q     <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      index_q     <= index_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
